// File: rtl/sram_arb_pkg.sv
// Shared constants for the single-port SRAM arbiter: response-owner encoding and starvation default.
// No logic; imported by the arbiter top and its starvation counter.
// No flow control of its own.
package sram_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_INST = 2'd1;
    localparam owner_t OWN_DATA = 2'd2;

    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating count of consecutive cycles a pending fetch was refused the SRAM.
// Latency: at_limit reflects the registered count (updates on the rising edge).
// Backpressure: none; inc saturates at LIMIT, clr wins over inc.
module sram_arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency single-port SRAM between fetch and data; data has priority, fetch is starvation-protected.
// Latency: grant is combinational; read data returns the cycle after the grant, writes produce no response.
// Backpressure: losing requester holds its request; read responses cannot be stalled.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    logic   at_limit;
    logic   inst_win;
    logic   data_win;
    owner_t owner;
    owner_t owner_nxt;
    logic [31:0] hold_inst;
    logic [31:0] hold_data;

    // Grants are gated by resetn so the SRAM stays idle while reset is held.
    assign inst_win = resetn & inst_req & (~data_req | at_limit);
    assign data_win = resetn & data_req & ~inst_win;

    assign inst_gnt = inst_win;
    assign data_gnt = data_win;
    assign sram_en  = inst_win | data_win;

    always_comb begin
        sram_addr  = '0;
        sram_wen   = 4'h0;
        sram_wdata = 32'h0;
        if (inst_win) begin
            sram_addr = inst_addr;
        end else if (data_win) begin
            sram_addr  = data_addr;
            sram_wen   = data_wen;
            sram_wdata = data_wdata;
        end
    end

    sram_arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .resetn  (resetn),
        .inc     (inst_req & ~inst_win),
        .clr     (~inst_req | inst_win),
        .at_limit(at_limit)
    );

    always_comb begin
        owner_nxt = OWN_NONE;
        if (inst_win) begin
            owner_nxt = OWN_INST;
        end else if (data_win && (data_wen == 4'h0)) begin
            owner_nxt = OWN_DATA;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner     <= OWN_NONE;
            hold_inst <= 32'h0;
            hold_data <= 32'h0;
        end else begin
            owner <= owner_nxt;
            if (owner == OWN_INST) hold_inst <= sram_rdata;
            if (owner == OWN_DATA) hold_data <= sram_rdata;
        end
    end

    assign inst_rvalid = (owner == OWN_INST);
    assign data_rvalid = (owner == OWN_DATA);
    assign inst_rdata  = inst_rvalid ? sram_rdata : hold_inst;
    assign data_rdata  = data_rvalid ? sram_rdata : hold_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a transaction-level reference model.
// Outputs are compared against the model every cycle at the falling edge, plus hand-computed literal checks.
// Inputs change 1 time unit after the rising edge.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_gnt;
    logic          inst_rvalid;
    logic [31:0]   inst_rdata;
    logic          data_req;
    logic [3:0]    data_wen;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [31:0]   data_rdata;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural single-port SRAM, 1-cycle read latency, word-indexed by addr[9:0].
    logic [31:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'h0) begin
                sram_rdata <= sram_mem[sram_addr[9:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) sram_mem[sram_addr[9:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state: what the requesters should observe.
    logic [31:0] m_mem [0:1023];
    int          m_refused;   // consecutive cycles the fetch has been turned away
    int          m_pend;      // 0 none, 1 fetch response due, 2 load response due
    logic [31:0] m_data;
    logic [31:0] m_hold_i;
    logic [31:0] m_hold_d;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic fetch_wins();
        return inst_req && (!data_req || m_refused >= LIMIT);
    endfunction

    task automatic compare();
        logic e_ig, e_dg;
        if (!resetn) begin
            chk("rst_sram_en", 32'(sram_en), 0);
            chk("rst_sram_wen", 32'(sram_wen), 0);
            chk("rst_sram_addr", sram_addr, 0);
            chk("rst_sram_wdata", sram_wdata, 0);
            chk("rst_gnts", {30'b0, inst_gnt, data_gnt}, 0);
            chk("rst_rvalids", {30'b0, inst_rvalid, data_rvalid}, 0);
            chk("rst_inst_rdata", inst_rdata, 0);
            chk("rst_data_rdata", data_rdata, 0);
        end else begin
            e_ig = fetch_wins();
            e_dg = data_req && !e_ig;
            chk("inst_gnt", 32'(inst_gnt), 32'(e_ig));
            chk("data_gnt", 32'(data_gnt), 32'(e_dg));
            chk("sram_en", 32'(sram_en), 32'(e_ig || e_dg));
            if (e_ig) chk("sram_addr_inst", sram_addr, inst_addr);
            if (e_dg) begin
                chk("sram_addr_data", sram_addr, data_addr);
                chk("sram_wen", 32'(sram_wen), 32'(data_wen));
                chk("sram_wdata", sram_wdata, data_wdata);
            end else begin
                chk("sram_wen_idle", 32'(sram_wen), 0);
                chk("sram_wdata_idle", sram_wdata, 0);
            end
            chk("inst_rvalid", 32'(inst_rvalid), 32'(m_pend == 1));
            chk("data_rvalid", 32'(data_rvalid), 32'(m_pend == 2));
            chk("inst_rdata", inst_rdata, (m_pend == 1) ? m_data : m_hold_i);
            chk("data_rdata", data_rdata, (m_pend == 2) ? m_data : m_hold_d);
        end
    endtask

    task automatic model_update();
        logic e_ig, e_dg;
        if (!resetn) begin
            m_pend = 0; m_refused = 0; m_hold_i = 0; m_hold_d = 0; m_data = 0;
        end else begin
            e_ig = fetch_wins();
            e_dg = data_req && !e_ig;
            if (m_pend == 1) m_hold_i = m_data;
            if (m_pend == 2) m_hold_d = m_data;
            m_pend = 0;
            if (e_ig) begin
                m_pend = 1; m_data = m_mem[inst_addr[9:0]];
            end else if (e_dg && data_wen == 4'h0) begin
                m_pend = 2; m_data = m_mem[data_addr[9:0]];
            end else if (e_dg) begin
                for (int b = 0; b < 4; b++)
                    if (data_wen[b]) m_mem[data_addr[9:0]][8*b +: 8] = data_wdata[8*b +: 8];
            end
            if (inst_req && !e_ig) m_refused = (m_refused >= LIMIT) ? LIMIT : m_refused + 1;
            else m_refused = 0;
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        inst_req = ir; inst_addr = ia; data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic sample();
        @(negedge clk);
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        m_pend = 0; m_refused = 0; m_hold_i = 0; m_hold_d = 0; m_data = 0;
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 32'h0;
            m_mem[i]    = 32'h0;
        end
        sram_mem[10'h100] = 32'hAAAA0001; m_mem[10'h100] = 32'hAAAA0001;
        sram_mem[10'h200] = 32'hBBBB0002; m_mem[10'h200] = 32'hBBBB0002;
        sram_mem[10'h104] = 32'hC0DE0104; m_mem[10'h104] = 32'hC0DE0104;
        sram_mem[10'h314] = 32'h11223344; m_mem[10'h314] = 32'h11223344;

        // Reset held with random requests: everything must stay quiet.
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom), $urandom, $urandom);
            sample();
            chk("lit_rst_sram_en", 32'(sram_en), 0);
            chk("lit_rst_gnt", {30'b0, inst_gnt, data_gnt}, 0);
            advance();
        end
        resetn = 1'b1;
        idle();
        sample();
        chk("lit_idle_sram_en", 32'(sram_en), 0);
        chk("lit_idle_rvalid", {30'b0, inst_rvalid, data_rvalid}, 0);
        advance();

        // Alternating single reads.
        drive(1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0);
        sample(); chk("lit_alt_inst_gnt", 32'(inst_gnt), 1); advance();
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        sample();
        chk("lit_alt_inst_rvalid", 32'(inst_rvalid), 1);
        chk("lit_alt_inst_rdata", inst_rdata, 32'hAAAA0001);
        chk("lit_alt_data_gnt", 32'(data_gnt), 1);
        advance();
        idle();
        sample();
        chk("lit_alt_data_rvalid", 32'(data_rvalid), 1);
        chk("lit_alt_data_rdata", data_rdata, 32'hBBBB0002);
        chk("lit_alt_inst_hold", inst_rdata, 32'hAAAA0001);
        advance();
        sample();
        chk("lit_alt_data_hold", data_rdata, 32'hBBBB0002);
        advance();

        // Continuous contention: fetch wins every fifth cycle.
        drive(1'b1, 32'h104, 1'b1, 4'h0, 32'h200, 32'h0);
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("lit_contend_inst_gnt", 32'(inst_gnt), 32'((k % 5) == 4));
            advance();
        end
        idle(); sample(); advance();

        // Full-word write followed by a fetch of the same word.
        drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h300, 32'h12345678);
        sample(); chk("lit_wr_sram_wen", 32'(sram_wen), 32'hF); advance();
        drive(1'b1, 32'h300, 1'b0, 4'h0, 32'h0, 32'h0);
        sample(); chk("lit_wr_no_data_rvalid", 32'(data_rvalid), 0); advance();
        idle();
        sample(); chk("lit_wr_fetch_rdata", inst_rdata, 32'h12345678); advance();

        // Byte-lane writes.
        drive(1'b0, 32'h0, 1'b1, 4'b0010, 32'h310, 32'h0000AB00); sample(); advance();
        drive(1'b0, 32'h0, 1'b1, 4'b0010, 32'h314, 32'hFFFFABFF); sample(); advance();
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h310, 32'h0);           sample(); advance();
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h314, 32'h0);
        sample(); chk("lit_byte_rd0", data_rdata, 32'h0000AB00); advance();
        idle();
        sample(); chk("lit_byte_rd1", data_rdata, 32'h1122AB44); advance();

        // Back-to-back mix: write, fetch same word, contended load, refused fetch retried.
        drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h320, 32'hCAFEF00D);   sample(); advance();
        drive(1'b1, 32'h320, 1'b1, 4'h0, 32'h320, 32'h0);        sample(); advance();
        drive(1'b1, 32'h320, 1'b0, 4'h0, 32'h0, 32'h0);          sample(); advance();
        drive(1'b1, 32'h104, 1'b1, 4'h0, 32'h100, 32'h0);
        sample();
        chk("lit_mix_inst_rdata", inst_rdata, 32'hCAFEF00D);
        advance();
        drive(1'b1, 32'h104, 1'b0, 4'h0, 32'h0, 32'h0);
        sample(); chk("lit_mix_data_rdata", data_rdata, 32'hAAAA0001); advance();
        idle();
        sample(); chk("lit_mix_inst_rdata2", inst_rdata, 32'hC0DE0104); advance();

        // Reset asserted between a load grant and its response edge.
        drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
        sample(); chk("lit_rstmid_gnt", 32'(data_gnt), 1);
        #1 resetn = 1'b0;
        advance();
        idle();
        sample(); chk("lit_rstmid_rvalid_in_rst", 32'(data_rvalid), 0); advance();
        resetn = 1'b1;
        sample();
        chk("lit_rstmid_rvalid", 32'(data_rvalid), 0);
        chk("lit_rstmid_rdata", data_rdata, 0);
        advance();
        sample(); advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
